fp_multiply: RTL and testbench

FP_MULTIPLY -- requirements
Module: fp_multiply

---
 rtl/fp_multiply.sv | 176 +++++++++++++++++
 tb/tb_fp_multiply.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiply.sv
// Single-precision multiplier, 24-cycle shift-add core, flush-to-zero; special operands finish 1 edge after accept, others 26.
// One operation in flight; result held in DONE until out_ready. Define FP_ROUND_NEAREST_EN for RNE rounding, else truncation.
module fp_multiply (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] MULT  = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [4:0]  cnt;
  logic [47:0] mcand;
  logic [23:0] mplier;
  logic [47:0] prod;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand classification; exponent 0 counts as zero regardless of fraction.
  logic       sign_p;
  logic       a_nan, a_inf, a_zero;
  logic       b_nan, b_inf, b_zero;
  assign sign_p = a_r[31] ^ b_r[31];
  assign a_nan  = (&a_r[30:23]) & (|a_r[22:0]);
  assign a_inf  = (&a_r[30:23]) & ~(|a_r[22:0]);
  assign a_zero = ~(|a_r[30:23]);
  assign b_nan  = (&b_r[30:23]) & (|b_r[22:0]);
  assign b_inf  = (&b_r[30:23]) & ~(|b_r[22:0]);
  assign b_zero = ~(|b_r[30:23]);

  logic        spec_hit;
  logic [31:0] spec_res;
  logic        spec_z, spec_i, spec_n;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = 32'h0;
    spec_z   = 1'b0;
    spec_i   = 1'b0;
    spec_n   = 1'b0;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
      spec_res = 32'h7FC0_0000;
      spec_n   = 1'b1;
    end else if (a_inf | b_inf) begin
      spec_res = {sign_p, 8'hFF, 23'h0};
      spec_i   = 1'b1;
    end else if (a_zero | b_zero) begin
      spec_res = {sign_p, 31'h0};
      spec_z   = 1'b1;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Normalise: the product of two [1,2) significands lies in [1,4).
  logic        norm_hi;
  logic [22:0] mant;
  logic [9:0]  exp_sum;
  logic [9:0]  exp_fin;
  logic [22:0] frac_fin;

  assign norm_hi = prod[47];
  assign mant    = norm_hi ? prod[46:24] : prod[45:23];
  assign exp_sum = {2'b00, a_r[30:23]} + {2'b00, b_r[30:23]} + {9'd0, norm_hi} - 10'd127;

`ifdef FP_ROUND_NEAREST_EN
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_rnd;
  assign guard    = norm_hi ? prod[23] : prod[22];
  assign sticky   = norm_hi ? (|prod[22:0]) : (|prod[21:0]);
  assign round_up = guard & (sticky | mant[0]);
  assign mant_rnd = {1'b0, mant} + {23'd0, round_up};
  // A carry out leaves the fraction bits all zero, which is exactly 1.0 at exponent+1.
  assign frac_fin = mant_rnd[22:0];
  assign exp_fin  = exp_sum + {9'd0, mant_rnd[23]};
`else
  assign frac_fin = mant;
  assign exp_fin  = exp_sum;
`endif

  logic ovf, unf;
  assign ovf = ($signed(exp_fin) >= 10'sd255);
  assign unf = ($signed(exp_fin) <= 10'sd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_r     <= 32'h0;
      b_r     <= 32'h0;
      cnt     <= 5'd0;
      mcand   <= 48'h0;
      mplier  <= 24'h0;
      prod    <= 48'h0;
      result  <= 32'h0;
      is_zero <= 1'b0;
      is_inf  <= 1'b0;
      is_nan  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (spec_hit) begin
            result  <= spec_res;
            is_zero <= spec_z;
            is_inf  <= spec_i;
            is_nan  <= spec_n;
            state   <= DONE;
          end else begin
            cnt    <= 5'd0;
            prod   <= 48'h0;
            mcand  <= {24'd0, 1'b1, a_r[22:0]};
            mplier <= {1'b1, b_r[22:0]};
            state  <= MULT;
          end
        end
        MULT: begin
          if (mplier[0]) begin
            prod <= prod + mcand;
          end
          mcand  <= {mcand[46:0], 1'b0};
          mplier <= {1'b0, mplier[23:1]};
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd23) begin
            state <= NORM;
          end
        end
        NORM: begin
          if (ovf) begin
            result <= {sign_p, 8'hFF, 23'h0};
            is_inf <= 1'b1;
          end else if (unf) begin
            result  <= {sign_p, 31'h0};
            is_zero <= 1'b1;
          end else begin
            result <= {sign_p, exp_fin[7:0], frac_fin};
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            is_zero <= 1'b0;
            is_inf  <= 1'b0;
            is_nan  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiply.sv
// Scoreboard bench for fp_multiply: randomized and directed operands against an arithmetic reference model.
module tb_fp_multiply;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        is_zero, is_inf, is_nan;

  fp_multiply dut (
    .clock     (clock),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .is_zero   (is_zero),
    .is_inf    (is_inf),
    .is_nan    (is_nan)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        z, i, n;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: IEEE single multiply with flush-to-zero, exact integer product then rounding.
  function automatic exp_t ref_mul(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    logic s;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy;
    logic xnan, xinf, xzero, ynan, yinf, yzero;
    longint unsigned p, q;
    int e, sh;
    s  = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    xnan = (ex == 8'hFF) && (fx != 0); xinf = (ex == 8'hFF) && (fx == 0); xzero = (ex == 0);
    ynan = (ey == 8'hFF) && (fy != 0); yinf = (ey == 8'hFF) && (fy == 0); yzero = (ey == 0);
    r.res = 32'h0; r.z = 0; r.i = 0; r.n = 0; r.lat = 1; r.acc = 0;
    if (xnan || ynan || (xinf && yzero) || (yinf && xzero)) begin
      r.res = 32'h7FC0_0000; r.n = 1;
    end else if (xinf || yinf) begin
      r.res = {s, 8'hFF, 23'h0}; r.i = 1;
    end else if (xzero || yzero) begin
      r.res = {s, 31'h0}; r.z = 1;
    end else begin
      r.lat = 26;
      p  = ({40'd0, 1'b1, fx}) * ({40'd0, 1'b1, fy});
      e  = int'(ex) + int'(ey) - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e++;
      end
      q = p >> sh;
`ifdef FP_ROUND_NEAREST_EN
      begin
        longint unsigned rem, half;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
          q = q >> 1;
          e++;
        end
      end
`endif
      if (e >= 255) begin
        r.res = {s, 8'hFF, 23'h0}; r.i = 1;
      end else if (e <= 0) begin
        r.res = {s, 31'h0}; r.z = 1;
      end else begin
        r.res = {s, 8'(e), q[22:0]};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    s = 1'($urandom);
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0: begin e = 8'h00; if ($urandom_range(0, 1) == 0) f = 23'h0; end
      1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'h0; end
      2: e = 8'($urandom_range(1, 25));
      3: e = 8'($urandom_range(230, 254));
      4: begin e = 8'($urandom_range(100, 150)); f = 23'h7FFFFF ^ 23'($urandom_range(0, 7)); end
      default: e = 8'($urandom_range(64, 190));
    endcase
    return {s, e, f};
  endfunction

  // Monitor / scoreboard consumer
  bit          seen     = 0;
  bit          idle_chk = 0;
  logic [31:0] held;
  int          hold_req = 0;
  int          hold_cnt = 0;
  exp_t        mon_e;

  always @(negedge clock) begin
    if (reset) begin
      seen      = 0;
      idle_chk  = 0;
      out_ready = 1'b0;
    end else begin
      if (idle_chk) begin
        check("idle_after_xfer", 32'({in_ready, out_valid}), 32'h2);
        idle_chk = 0;
      end
      if (out_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %h with no pending operation", result);
          end else begin
            mon_e = exp_q.pop_front();
            check("result", result, mon_e.res);
            check("flags", 32'({is_zero, is_inf, is_nan}), 32'({mon_e.z, mon_e.i, mon_e.n}));
            check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          end
          seen     = 1;
          held     = result;
          hold_cnt = hold_req;
          hold_req = 0;
        end else begin
          check("hold_result", result, held);
          check("hold_in_ready", 32'(in_ready), 32'h0);
        end
        if (hold_cnt > 0) begin
          out_ready = 1'b0;
          hold_cnt--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (out_ready) begin
          seen     = 0;
          idle_chk = 1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, 32'({in_ready, out_valid, is_zero, is_inf, is_nan}), 32'h10);
    check({name, "_result"}, result, 32'h0);
  endtask

  // Issue one operation; in_valid stays high with garbage operands through the CHECK edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int   waitc;
    exp_t e;
    waitc = 0;
    while (!in_ready && waitc < 200) begin
      @(negedge clock);
      waitc++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready %b after %0d cycles, required 1", in_ready, waitc);
      return;
    end
    a = x; b = y; in_valid = 1'b1;
    @(posedge clock); #1;
    e = ref_mul(x, y);
    e.acc = cyc;
    exp_q.push_back(e);
    a = $urandom; b = $urandom;
    @(posedge clock); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = 32'h0; b = 32'h0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_init");
    reset = 1'b0;

    send(32'h3FC0_0000, 32'h4000_0000);
    send(32'h7F80_0000, 32'h0000_0000);
    send(32'hFF80_0000, 32'h4000_0000);
    send(32'h3F80_0001, 32'h4040_0000);
    send(32'h7F00_0000, 32'h7F00_0000);
    send(32'h0080_0000, 32'h0080_0000);
    send(32'h8040_0000, 32'h3F80_0000);
    send(32'h7FC0_1234, 32'h3F80_0000);
    send(32'h3FFF_FFFF, 32'h3FFF_FFFF);

    hold_req = 10;
    send(32'h3FC0_0000, 32'h4000_0000);

    // Abort at MULT iteration 10, then restart on the first edge after reset drops.
    send(32'h4040_0000, 32'h4040_0000);
    repeat (11) @(posedge clock);
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_op");
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    send(32'h4000_0000, 32'h4000_0000);

    for (int k = 0; k < 150; k++) begin
      send(rand_op(), rand_op());
    end

    for (int w = 0; w < 500 && (exp_q.size() != 0 || !in_ready); w++) begin
      @(negedge clock);
    end
    if (exp_q.size() != 0 || !in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, in_ready %b", exp_q.size(), in_ready);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
